// File: rtl/cpu_datapath_pkg.sv
// Shared encodings and width constants for the cpu_datapath block.
// Strobe encodings must match the multi-cycle control unit exactly.
package cpu_datapath_pkg;

    localparam int DP_DATA_WIDTH = 8;
    localparam int DP_PC_WIDTH   = 5;
    localparam int DP_NUM_REGS   = 4;

    localparam logic [1:0] ALU_NULL = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;
    localparam logic [1:0] ALU_NAND = 2'd3;

    localparam logic REG_SRC_ALU  = 1'b0;
    localparam logic REG_SRC_RAM  = 1'b1;

    localparam logic MEM_ADDR_PC  = 1'b0;
    localparam logic MEM_ADDR_IR  = 1'b1;

    localparam logic PC_SRC_INC   = 1'b0;
    localparam logic PC_SRC_JUMP  = 1'b1;

endpackage

// File: rtl/cpu_datapath_reg_file.sv
// Register file: two combinational read ports, one write port on the clock edge.
// A same-cycle read of the index being written returns the old contents.
module reg_file
    import cpu_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = DP_DATA_WIDTH,
    parameter int NUM_REGS   = DP_NUM_REGS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
    input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0]       rdata_a,
    output logic [DATA_WIDTH-1:0]       rdata_b
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath: PC, IR, register file, ALU with result latch, MDR, zero flag.
// Build option DATAPATH_CARRY_FLAG_EN adds a carry_flag output latched with alu_out.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int DATA_WIDTH = DP_DATA_WIDTH,
    parameter int PC_WIDTH   = DP_PC_WIDTH,
    parameter int NUM_REGS   = DP_NUM_REGS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pc_write,
    input  logic                        pc_src,
    input  logic                        ir_write,
    input  logic                        reg_write,
    input  logic                        reg_src,
    input  logic [$clog2(NUM_REGS)-1:0] reg_dest,
    input  logic [1:0]                  alu_op,
    input  logic [$clog2(NUM_REGS)-1:0] alu_src1,
    input  logic [$clog2(NUM_REGS)-1:0] alu_src2,
    input  logic                        imm_sel,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic                        mem_addr_src,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic [DATA_WIDTH-1:0]       instruction,
    output logic                        zero_flag,
`ifdef DATAPATH_CARRY_FLAG_EN
    output logic                        carry_flag,
`endif
    output logic [PC_WIDTH-1:0]         pc,
    output logic [PC_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic                        mem_we,
    output logic                        mem_re
);

`ifdef DATAPATH_CARRY_FLAG_EN
    localparam int ALU_W = DATA_WIDTH + 1;
`else
    localparam int ALU_W = DATA_WIDTH;
`endif

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] alu_out_q, alu_out_d;
    logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
    logic                  zero_q, zero_d;
`ifdef DATAPATH_CARRY_FLAG_EN
    logic                  carry_q, carry_d;
`endif

    logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [ALU_W-1:0]      alu_wide;
    logic [DATA_WIDTH-1:0] alu_result;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .we      (reg_write),
        .waddr   (reg_dest),
        .wdata   (wb_data),
        .raddr_a (alu_src1),
        .raddr_b (alu_src2),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // imm2 reuses the port-B select bits, zero-extended.
    assign operand_b = imm_sel ? DATA_WIDTH'(alu_src2) : rdata_b;

    // With the carry option the ALU runs one bit wider; the top bit is carry/borrow.
    always_comb begin
        alu_wide = '0;
        case (alu_op)
            ALU_ADD:  alu_wide = ALU_W'(rdata_a) + ALU_W'(operand_b);
            ALU_SUB:  alu_wide = ALU_W'(rdata_a) - ALU_W'(operand_b);
            ALU_NAND: alu_wide = ALU_W'(~(rdata_a & operand_b));
            default:  alu_wide = '0;
        endcase
    end

    assign alu_result = alu_wide[DATA_WIDTH-1:0];
    assign wb_data    = (reg_src == REG_SRC_RAM) ? mdr_q : alu_out_q;

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        alu_out_d = alu_out_q;
        zero_d    = zero_q;
`ifdef DATAPATH_CARRY_FLAG_EN
        carry_d   = carry_q;
`endif
        if (pc_write) begin
            pc_d = (pc_src == PC_SRC_JUMP) ? ir_q[PC_WIDTH-1:0] : pc_q + 1'b1;
        end
        if (ir_write) begin
            ir_d = mem_rdata;
        end
        if (mem_read) begin
            mdr_d = mem_rdata;
        end
        // Flags only move with a real ALU op, so JZ sees the last arithmetic result.
        if (alu_op != ALU_NULL) begin
            alu_out_d = alu_result;
            zero_d    = (alu_result == '0);
`ifdef DATAPATH_CARRY_FLAG_EN
            carry_d   = (alu_op == ALU_NAND) ? 1'b0 : alu_wide[ALU_W-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
            zero_q    <= 1'b0;
`ifdef DATAPATH_CARRY_FLAG_EN
            carry_q   <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
`ifdef DATAPATH_CARRY_FLAG_EN
            carry_q   <= carry_d;
`endif
        end
    end

    assign instruction = ir_q;
    assign zero_flag   = zero_q;
    assign pc          = pc_q;
`ifdef DATAPATH_CARRY_FLAG_EN
    assign carry_flag  = carry_q;
`endif
    assign mem_addr    = (mem_addr_src == MEM_ADDR_IR) ? ir_q[PC_WIDTH-1:0] : pc_q;
    assign mem_wdata   = rdata_a;
    assign mem_we      = mem_write;
    assign mem_re      = mem_read;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed scenarios plus randomized strobes against an arithmetic model.
// Define DATAPATH_CARRY_FLAG_EN to also exercise carry_flag.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pc_write, pc_src, ir_write, reg_write, reg_src;
    logic [1:0] reg_dest, alu_op, alu_src1, alu_src2;
    logic       imm_sel, mem_read, mem_write, mem_addr_src;
    logic [7:0] mem_rdata;
    logic [7:0] instruction;
    logic       zero_flag;
    logic [4:0] pc, mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re;
`ifdef DATAPATH_CARRY_FLAG_EN
    logic       carry_flag;
    logic       m_cf;
`endif

    int checks = 0;
    int failures = 0;

    logic [4:0] m_pc;
    logic [7:0] m_ir, m_alu, m_mdr;
    logic [7:0] m_regs [4];
    logic       m_zf;

    cpu_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .ir_write     (ir_write),
        .reg_write    (reg_write),
        .reg_src      (reg_src),
        .reg_dest     (reg_dest),
        .alu_op       (alu_op),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .imm_sel      (imm_sel),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_src (mem_addr_src),
        .mem_rdata    (mem_rdata),
        .instruction  (instruction),
        .zero_flag    (zero_flag),
`ifdef DATAPATH_CARRY_FLAG_EN
        .carry_flag   (carry_flag),
`endif
        .pc           (pc),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re)
    );

    // Clock / watchdog
    always #10 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: next state from the behavioural rules using integer arithmetic.
    task automatic model_step();
        int a, b, r;
        logic c;
        logic [4:0] n_pc;
        if (reset) begin
            m_pc = '0; m_ir = '0; m_alu = '0; m_mdr = '0; m_zf = 1'b0;
`ifdef DATAPATH_CARRY_FLAG_EN
            m_cf = 1'b0;
`endif
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            return;
        end
        a = int'(m_regs[alu_src1]);
        b = imm_sel ? int'(alu_src2) : int'(m_regs[alu_src2]);
        r = 0;
        c = 1'b0;
        case (alu_op)
            2'd1: begin r = (a + b) % 256; c = (a + b) > 255; end
            2'd2: begin r = (a - b + 256) % 256; c = (a < b); end
            2'd3: begin r = 255 - (a & b); c = 1'b0; end
            default: ;
        endcase
        n_pc = m_pc;
        if (pc_write) n_pc = pc_src ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
        if (reg_write) m_regs[reg_dest] = reg_src ? m_mdr : m_alu;
        if (ir_write) m_ir = mem_rdata;
        if (mem_read) m_mdr = mem_rdata;
        if (alu_op != 2'd0) begin
            m_alu = 8'(r);
            m_zf  = (r == 0);
`ifdef DATAPATH_CARRY_FLAG_EN
            m_cf  = c;
`endif
        end
        m_pc = n_pc;
    endtask

    // Driver tasks
    task automatic clear_strobes();
        reset = 1'b0; pc_write = 1'b0; pc_src = 1'b0; ir_write = 1'b0;
        reg_write = 1'b0; reg_src = 1'b0; reg_dest = 2'd0; alu_op = ALU_NULL;
        alu_src1 = 2'd0; alu_src2 = 2'd0; imm_sel = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; mem_addr_src = 1'b0; mem_rdata = 8'h00;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek_reg(input int idx, output logic [7:0] v);
        alu_src1 = 2'(idx);
        #1;
        v = mem_wdata;
    endtask

    task automatic load_reg(input int idx, input logic [7:0] v);
        clear_strobes();
        mem_read = 1'b1; mem_rdata = v;
        tick();
        clear_strobes();
        reg_write = 1'b1; reg_src = REG_SRC_RAM; reg_dest = 2'(idx);
        tick();
        clear_strobes();
    endtask

    task automatic set_ir(input logic [7:0] v);
        clear_strobes();
        ir_write = 1'b1; mem_rdata = v;
        tick();
        clear_strobes();
    endtask

    task automatic set_pc(input logic [4:0] p);
        set_ir({3'b000, p});
        pc_write = 1'b1; pc_src = PC_SRC_JUMP;
        tick();
        clear_strobes();
    endtask

    task automatic writeback_alu(input int idx);
        clear_strobes();
        reg_write = 1'b1; reg_src = REG_SRC_ALU; reg_dest = 2'(idx);
        tick();
        clear_strobes();
    endtask

    // Scenarios
    task automatic test_reset();
        logic [7:0] v;
        clear_strobes();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (pc !== 5'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        checks++; if (instruction !== 8'h00) begin failures++; $display("FAIL reset_ir got=%0h exp=0", instruction); end
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL reset_zf got=%0b exp=0", zero_flag); end
        for (int i = 0; i < 4; i++) begin
            peek_reg(i, v);
            checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%0h exp=0", i, v); end
        end
        load_reg(2, 8'h55);
        set_pc(5'd7);
        peek_reg(2, v);
        checks++; if (v !== 8'h55 || pc !== 5'd7) begin failures++; $display("FAIL pre_reset got r2=%0h pc=%0h exp r2=55 pc=7", v, pc); end
        pc_write = 1'b1; ir_write = 1'b1; reg_write = 1'b1; reg_dest = 2'd2;
        alu_op = ALU_ADD; alu_src1 = 2'd2; alu_src2 = 2'd2; mem_read = 1'b1; mem_rdata = 8'h99;
        reset = 1'b1;
        tick();
        clear_strobes();
        peek_reg(2, v);
        checks++; if (pc !== 5'd0) begin failures++; $display("FAIL midreset_pc got=%0h exp=0", pc); end
        checks++; if (instruction !== 8'h00) begin failures++; $display("FAIL midreset_ir got=%0h exp=0", instruction); end
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL midreset_r2 got=%0h exp=0", v); end
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL midreset_zf got=%0b exp=0", zero_flag); end
        checks++; if (mem_addr !== 5'd0) begin failures++; $display("FAIL midreset_addr got=%0h exp=0", mem_addr); end
    endtask

    task automatic test_fetch();
        set_pc(5'd3);
        ir_write = 1'b1; pc_write = 1'b1; pc_src = PC_SRC_INC; mem_rdata = 8'h2C;
        #1;
        checks++; if (mem_addr !== 5'd3) begin failures++; $display("FAIL fetch_addr got=%0h exp=3", mem_addr); end
        tick();
        clear_strobes();
        checks++; if (instruction !== 8'h2C) begin failures++; $display("FAIL fetch_ir got=%0h exp=2c", instruction); end
        checks++; if (pc !== 5'd4) begin failures++; $display("FAIL fetch_pc got=%0h exp=4", pc); end
        set_pc(5'd31);
        ir_write = 1'b1; pc_write = 1'b1; pc_src = PC_SRC_INC; mem_rdata = 8'h81;
        tick();
        clear_strobes();
        checks++; if (pc !== 5'd0) begin failures++; $display("FAIL fetch_wrap_pc got=%0h exp=0", pc); end
        checks++; if (instruction !== 8'h81) begin failures++; $display("FAIL fetch_wrap_ir got=%0h exp=81", instruction); end
    endtask

    task automatic test_alu();
        logic [7:0] v;
        load_reg(1, 8'hF0);
        load_reg(2, 8'h20);
        alu_op = ALU_ADD; alu_src1 = 2'd1; alu_src2 = 2'd2;
        tick();
        writeback_alu(1);
        peek_reg(1, v);
        checks++; if (v !== 8'h10) begin failures++; $display("FAIL add_r1 got=%0h exp=10", v); end
        checks++; if (zero_flag !== 1'b0) begin failures++; $display("FAIL add_zf got=%0b exp=0", zero_flag); end
        alu_op = ALU_SUB; imm_sel = 1'b1; alu_src1 = 2'd1; alu_src2 = 2'd0;
        tick();
        writeback_alu(3);
        peek_reg(3, v);
        checks++; if (v !== 8'h10 || zero_flag !== 1'b0) begin failures++; $display("FAIL subimm0 got r3=%0h zf=%0b exp r3=10 zf=0", v, zero_flag); end
        load_reg(1, 8'h02);
        alu_op = ALU_SUB; imm_sel = 1'b1; alu_src1 = 2'd1; alu_src2 = 2'd2;
        tick();
        clear_strobes();
        checks++; if (zero_flag !== 1'b1) begin failures++; $display("FAIL subimm2_zf got=%0b exp=1", zero_flag); end
        writeback_alu(3);
        peek_reg(3, v);
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL subimm2_r3 got=%0h exp=0", v); end
    endtask

    task automatic test_load();
        logic [7:0] v;
        logic       zf_before;
        set_ir(8'h1E);
        zf_before = zero_flag;
        mem_addr_src = MEM_ADDR_IR; mem_read = 1'b1; mem_rdata = 8'hA7;
        #1;
        checks++; if (mem_addr !== 5'h1E || mem_re !== 1'b1) begin failures++; $display("FAIL load_addr got addr=%0h re=%0b exp addr=1e re=1", mem_addr, mem_re); end
        tick();
        clear_strobes();
        reg_write = 1'b1; reg_src = REG_SRC_RAM; reg_dest = 2'd0; mem_rdata = 8'h00;
        tick();
        clear_strobes();
        peek_reg(0, v);
        checks++; if (v !== 8'hA7) begin failures++; $display("FAIL load_r0 got=%0h exp=a7", v); end
        checks++; if (zero_flag !== zf_before) begin failures++; $display("FAIL load_zf got=%0b exp=%0b", zero_flag, zf_before); end
    endtask

    task automatic test_store();
        load_reg(0, 8'h3C);
        set_ir(8'h5D);
        mem_write = 1'b1; mem_addr_src = MEM_ADDR_IR; alu_src1 = 2'd0;
        #1;
        checks++; if (mem_addr !== 5'h1D) begin failures++; $display("FAIL store_addr got=%0h exp=1d", mem_addr); end
        checks++; if (mem_wdata !== 8'h3C) begin failures++; $display("FAIL store_wdata got=%0h exp=3c", mem_wdata); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL store_we got=%0b exp=1", mem_we); end
        tick();
        clear_strobes();
    endtask

    task automatic test_jump_nand();
        logic [7:0] v;
        set_ir(8'hF3);
        pc_write = 1'b1; pc_src = PC_SRC_JUMP;
        tick();
        clear_strobes();
        checks++; if (pc !== 5'h13) begin failures++; $display("FAIL jump_pc got=%0h exp=13", pc); end
        load_reg(3, 8'hFF);
        alu_op = ALU_NAND; alu_src1 = 2'd3; alu_src2 = 2'd3;
        tick();
        writeback_alu(2);
        peek_reg(2, v);
        checks++; if (v !== 8'h00 || zero_flag !== 1'b1) begin failures++; $display("FAIL nand got r2=%0h zf=%0b exp r2=0 zf=1", v, zero_flag); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        load_reg(1, 8'h11);
        mem_read = 1'b1; mem_rdata = 8'h6B;
        tick();
        clear_strobes();
        reg_write = 1'b1; reg_src = REG_SRC_RAM; reg_dest = 2'd1; alu_src1 = 2'd1;
        #1;
        checks++; if (mem_wdata !== 8'h11) begin failures++; $display("FAIL same_cycle_old got=%0h exp=11", mem_wdata); end
        tick();
        clear_strobes();
        peek_reg(1, v);
        checks++; if (v !== 8'h6B) begin failures++; $display("FAIL next_cycle_new got=%0h exp=6b", v); end
    endtask

`ifdef DATAPATH_CARRY_FLAG_EN
    task automatic test_carry();
        load_reg(0, 8'h80);
        alu_op = ALU_ADD; alu_src1 = 2'd0; alu_src2 = 2'd0;
        tick();
        clear_strobes();
        checks++; if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin failures++; $display("FAIL carry_add got cf=%0b zf=%0b exp cf=1 zf=1", carry_flag, zero_flag); end
        load_reg(1, 8'h01);
        checks++; if (carry_flag !== 1'b1) begin failures++; $display("FAIL carry_hold got=%0b exp=1", carry_flag); end
        alu_op = ALU_NAND; alu_src1 = 2'd0; alu_src2 = 2'd0;
        tick();
        clear_strobes();
        checks++; if (carry_flag !== 1'b0) begin failures++; $display("FAIL carry_nand got=%0b exp=0", carry_flag); end
        alu_op = ALU_SUB; alu_src1 = 2'd1; alu_src2 = 2'd0;
        tick();
        clear_strobes();
        checks++; if (carry_flag !== 1'b1) begin failures++; $display("FAIL carry_borrow got=%0b exp=1", carry_flag); end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 39) == 0);
            pc_write     = 1'($urandom_range(0, 1));
            pc_src       = 1'($urandom_range(0, 1));
            ir_write     = 1'($urandom_range(0, 1));
            reg_write    = 1'($urandom_range(0, 1));
            reg_src      = 1'($urandom_range(0, 1));
            reg_dest     = 2'($urandom_range(0, 3));
            alu_op       = 2'($urandom_range(0, 3));
            alu_src1     = 2'($urandom_range(0, 3));
            alu_src2     = 2'($urandom_range(0, 3));
            imm_sel      = 1'($urandom_range(0, 1));
            mem_read     = 1'($urandom_range(0, 1));
            mem_write    = 1'($urandom_range(0, 1));
            mem_addr_src = 1'($urandom_range(0, 1));
            mem_rdata    = 8'($urandom_range(0, 255));
            #1;
            checks++; if (mem_addr !== (mem_addr_src ? m_ir[4:0] : m_pc)) begin failures++; $display("FAIL rnd_addr n=%0d got=%0h exp=%0h", n, mem_addr, mem_addr_src ? m_ir[4:0] : m_pc); end
            checks++; if (mem_wdata !== m_regs[alu_src1]) begin failures++; $display("FAIL rnd_wdata n=%0d got=%0h exp=%0h", n, mem_wdata, m_regs[alu_src1]); end
            checks++; if (mem_we !== mem_write || mem_re !== mem_read) begin failures++; $display("FAIL rnd_strobes n=%0d got we=%0b re=%0b exp we=%0b re=%0b", n, mem_we, mem_re, mem_write, mem_read); end
            tick();
            checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%0h exp=%0h", n, pc, m_pc); end
            checks++; if (instruction !== m_ir) begin failures++; $display("FAIL rnd_ir n=%0d got=%0h exp=%0h", n, instruction, m_ir); end
            checks++; if (zero_flag !== m_zf) begin failures++; $display("FAIL rnd_zf n=%0d got=%0b exp=%0b", n, zero_flag, m_zf); end
`ifdef DATAPATH_CARRY_FLAG_EN
            checks++; if (carry_flag !== m_cf) begin failures++; $display("FAIL rnd_cf n=%0d got=%0b exp=%0b", n, carry_flag, m_cf); end
`endif
        end
        clear_strobes();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alu();
        test_load();
        test_store();
        test_jump_nand();
        test_back_to_back();
`ifdef DATAPATH_CARRY_FLAG_EN
        test_carry();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
